syscall_input: RTL
==================

# syscall_input

Input-direction syscall engine for the MIPS pipeline. It services the console-read syscalls: read integer (v0=5), read string (v0=8) and read char (v0=12). While a read is in progress it holds the pipeline with `stall` and consumes bytes from a console receive stream. Results go to `$v0` through a writeback port, or to data memory through a byte-write port. It sits beside the print/exit syscall handler and decodes the same `syscall_control`/`v0`/`a0` inputs.

## Interface
- `MAXLEN`, default 32'h7FFF_FFFF: clamp on the read-string length taken from `a1`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `syscall_control` in 1: a syscall instruction is present and `v0`/`a0`/`a1` are valid.
- `v0` in 32: service code.
- `a0` in 32: buffer base address (read string).
- `a1` in 32: buffer length n, signed (read string).
- `rx_valid` in 1: console byte available.
- `rx_data` in 8: console byte.
- `rx_ready` out 1: engine accepts a byte this cycle.
- `mem_we` out 1: byte write strobe; the memory completes the write in the same cycle.
- `mem_addr` out 32: byte address.
- `mem_wdata` out 8: byte data.
- `result_we` out 1: write `result` into `$v0` at this edge.
- `result` out 32: syscall return value.
- `stall` out 1: hold the pipeline; the syscall instruction must not advance.

## Operation
- States: IDLE, RD_INT, RD_CHR, RD_STR, STR_NUL, DONE.
- IDLE:
  - `stall` = `syscall_control` & (`v0` ∈ {5, 8, 12}), combinational.
  - At the edge where this is true, latch `a0` as base and `a1` as n (min(n, `MAXLEN`)), clear the accumulator, count and negative flag, and go to RD_INT, RD_STR or RD_CHR.
  - Any other `v0` is ignored, with no stall.
- RD_INT:
  - `rx_ready`=1. A byte is accepted when `rx_valid`&`rx_ready`.
  - '0'..'9': acc = acc*10 + digit, modulo 2^32.
  - '-' as the first accepted byte sets the negative flag.
  - 0x0A: `result` = neg ? -acc : acc (two's complement), then DONE.
  - Any other byte is discarded.
- RD_CHR: `rx_ready`=1. The first accepted byte sets `result` = {24'b0, byte}, then DONE.
- RD_STR:
  - Entry with n ≤ 0: DONE immediately, no writes.
  - Entry with n = 1: STR_NUL with count 0.
  - Otherwise `rx_ready`=1. Each accepted byte drives `mem_we`=1, `mem_addr`=base+count, `mem_wdata`=byte in the same cycle, and count increments.
  - If the byte was 0x0A, or the new count = n−1: STR_NUL.
- STR_NUL: `mem_we`=1, `mem_addr`=base+count, `mem_wdata`=0, then DONE.
- DONE:
  - `stall`=0, so the pipeline advances the syscall at this edge.
  - `result_we`=1 only for services 5 and 12.
  - `syscall_control` is ignored in DONE; next state is IDLE.
- `stall`=1 in every non-IDLE state except DONE.
- Address arithmetic is 32-bit and wraps past 0xFFFF_FFFF.

## Timing
- All outputs are 0 while `rst_n` is low; `result` resets to 0.
- `rst_n` asserted mid-operation: return to IDLE, discard the accumulator and count. Bytes already written stay in memory; no null terminator is written.
- `rx_ready` is a registered function of state only. It never depends on `rx_valid` in the same cycle.
- Minimum latencies, from the start edge to the DONE cycle:
  - Read char: 2 cycles (one byte cycle, then DONE).
  - Read int "7\n": 3 cycles.
  - Read string of k bytes: k+2 cycles (k byte cycles, STR_NUL, DONE).
- Gaps on `rx_valid` extend the state with no side effects.
- `result` holds its value until the next completed service.
- A byte offered while in IDLE or DONE is not accepted; it stays pending at the source.

## Test plan
- Read int: v0=5, bytes "-","1","2","3",0x0A → `result_we` pulse with `result`=0xFFFF_FF85 (-123); `stall` high from the start edge until the DONE cycle.
- Read string: v0=8, a0=0x1000, a1=4, bytes "ab",0x0A,"z" → writes 0x1000='a', 0x1001='b', 0x1002=0x0A, 0x1003=0x00; 'z' not accepted; no `result_we`.
- Read string truncation and edge lengths:
  - a1=3, bytes "xyz" → 0x1000='x', 0x1001='y', 0x1002=0.
  - a1=1 → a single null write at a0.
  - a1=0 → no writes; 2-cycle stall.
- Read char with gaps: v0=12, `rx_valid` low for 5 cycles, then 0x41 → `result`=0x41 one cycle after acceptance; `rx_ready` low in DONE.
- Reset and unsupported codes:
  - `rst_n` low after 2 bytes of a read string → all outputs 0, no null write; a new v0=5 request after reset works normally.
  - v0=1 or v0=10 → no `stall`, no `rx_ready`.

Source files
------------

// File: rtl/syscall_input_if.sv
// Signal bundle between the pipeline/console/memory side and the input syscall engine.
// The engine uses the slave modport; the surrounding pipeline logic uses master.
interface syscall_input_if;
  logic        syscall_control;
  logic [31:0] v0;
  logic [31:0] a0;
  logic [31:0] a1;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        result_we;
  logic [31:0] result;
  logic        stall;

  modport master (
    output syscall_control, v0, a0, a1, rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata, result_we, result, stall
  );

  modport slave (
    input  syscall_control, v0, a0, a1, rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata, result_we, result, stall
  );
endinterface

// File: rtl/syscall_input.sv
// Console-read syscall engine (read int / read string / read char). Holds the
// pipeline while consuming console bytes; results go to $v0 or to data memory.
module syscall_input #(
  parameter int MAXLEN = 32'h7FFF_FFFF
) (
  input logic            clk,
  input logic            rst_n,
  syscall_input_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_INT  = 3'd1,
    RD_CHR  = 3'd2,
    RD_STR  = 3'd3,
    STR_NUL = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        base_q, base_d;
  logic signed [31:0] len_q, len_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               seen_q, seen_d;
  logic               wb_q, wb_d;
  logic [31:0]        result_q, result_d;
  logic               rx_ready_q, rx_ready_d;

  logic               start;
  logic               accept;
  logic               stall;
  logic               mem_we;
  logic [31:0]        mem_addr;
  logic [7:0]         mem_wdata;
  logic               result_we;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    seen_d     = seen_q;
    wb_d       = wb_q;
    result_d   = result_q;
    stall      = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 8'h0;
    result_we  = 1'b0;

    start  = bus.syscall_control &
             ((bus.v0 == 32'd5) | (bus.v0 == 32'd8) | (bus.v0 == 32'd12));
    accept = bus.rx_valid & rx_ready_q;

    unique case (state_q)
      IDLE: begin
        // The IDLE stall is combinational, so it must be forced low during reset.
        stall = start & rst_n;
        if (start) begin
          base_d = bus.a0;
          len_d  = ($signed(bus.a1) > MAXLEN) ? 32'(MAXLEN) : $signed(bus.a1);
          acc_d  = 32'h0;
          cnt_d  = 32'h0;
          neg_d  = 1'b0;
          seen_d = 1'b0;
          wb_d   = (bus.v0 != 32'd8);
          if (bus.v0 == 32'd5)      state_d = RD_INT;
          else if (bus.v0 == 32'd8) state_d = RD_STR;
          else                      state_d = RD_CHR;
        end
      end

      RD_INT: begin
        stall = 1'b1;
        if (accept) begin
          seen_d = 1'b1;
          if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
            acc_d = acc_q * 32'd10 + {28'h0, bus.rx_data[3:0]};
          end else if (bus.rx_data == 8'h2D && !seen_q) begin
            neg_d = 1'b1;
          end else if (bus.rx_data == 8'h0A) begin
            result_d = neg_q ? (32'h0 - acc_q) : acc_q;
            state_d  = DONE;
          end
        end
      end

      RD_CHR: begin
        stall = 1'b1;
        if (accept) begin
          result_d = {24'h0, bus.rx_data};
          state_d  = DONE;
        end
      end

      RD_STR: begin
        stall = 1'b1;
        if (len_q <= 0) begin
          state_d = DONE;
        end else if (len_q == 1) begin
          state_d = STR_NUL;
        end else if (accept) begin
          mem_we    = 1'b1;
          mem_addr  = base_q + cnt_q;
          mem_wdata = bus.rx_data;
          cnt_d     = cnt_q + 32'd1;
          // Leave one slot for the terminator.
          if (bus.rx_data == 8'h0A || cnt_d == $unsigned(len_q - 32'sd1)) state_d = STR_NUL;
        end
      end

      STR_NUL: begin
        stall     = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = base_q + cnt_q;
        mem_wdata = 8'h00;
        state_d   = DONE;
      end

      DONE: begin
        result_we = wb_q;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Registered, so the ready seen by the source depends only on the state being entered.
    rx_ready_d = (state_d == RD_INT) | (state_d == RD_CHR) |
                 ((state_d == RD_STR) & (len_d > 1));
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= 32'h0;
      len_q      <= 32'sh0;
      acc_q      <= 32'h0;
      cnt_q      <= 32'h0;
      neg_q      <= 1'b0;
      seen_q     <= 1'b0;
      wb_q       <= 1'b0;
      result_q   <= 32'h0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      seen_q     <= seen_d;
      wb_q       <= wb_d;
      result_q   <= result_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.result_we = result_we;
  assign bus.result    = result_q;

endmodule
